// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe
// Pipelined modular adder/subtractor over GF(Q). Each accepted operation
// selects add (A+B mod Q) or sub (A-B mod Q) and carries a sideband tag that
// emerges unchanged alongside its result.
//
// Pipeline: S1 holds the operands/op/tag, S2 holds the raw W+2 bit signed
// sum or difference, and S3 holds the corrected result (the output registers).
// All three stages advance together on adv = !out_valid || out_ready and all
// hold otherwise, so a stalled output freezes the whole pipe.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
// ready are both high. in_ready depends only on out_valid/out_ready, never on
// in_valid. A source that sees in_ready low must hold its inputs. out_d and
// out_tag keep their last values while out_valid is low.
//
// Optional build macro FP_ADDSUB_RANGE_CHK_EN adds range_err, which flags an
// operation whose A or B was >= Q. It travels with its op and is aligned with
// out_valid.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            input handshake
//   in_op                        0 = add, 1 = sub
//   in_a, in_b  [W-1:0]          operands, expected in [0, Q)
//   in_tag      [TAG_W-1:0]      sideband tag
//   out_valid/out_ready          output handshake
//   out_d       [W-1:0]          result
//   out_tag     [TAG_W-1:0]      tag of the op producing out_d
//   range_err                    (FP_ADDSUB_RANGE_CHK_EN only) operand >= Q

module fp_addsub_pipe #(
    parameter int             W     = 255,
    parameter logic [W-1:0]   Q     = 255'd2261564242916331941866620800950935700259179388000792266395655937654553313279,
    parameter int             TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_d,
    output logic [TAG_W-1:0] out_tag
`ifdef FP_ADDSUB_RANGE_CHK_EN
    ,
    output logic             range_err
`endif
);

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage 1: captured operands
    logic             s1_valid;
    logic             s1_op;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [TAG_W-1:0] s1_tag;

    // Stage 2: raw result, two extra bits so a subtraction keeps its sign
    logic             s2_valid;
    logic             s2_op;
    logic [W+1:0]     s2_r;
    logic [TAG_W-1:0] s2_tag;

    logic [W+1:0]     raw;
    logic [W-1:0]     corr;

    always_comb begin
        raw = '0;
        if (s1_op) begin
            raw = {2'b00, s1_a} - {2'b00, s1_b};
        end else begin
            raw = {2'b00, s1_a} + {2'b00, s1_b};
        end
    end

    // One conditional correction step. Only the low W bits survive, so the
    // +/-Q is done at W bits; the decision uses the full raw value.
    always_comb begin
        corr = s2_r[W-1:0];
        if (s2_op) begin
            if (s2_r[W+1]) begin
                corr = s2_r[W-1:0] + Q;
            end
        end else if (s2_r >= {2'b00, Q}) begin
            corr = s2_r[W-1:0] - Q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_d     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (in_valid) begin
                s1_op  <= in_op;
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_tag <= in_tag;
            end
            if (s1_valid) begin
                s2_op  <= s1_op;
                s2_r   <= raw;
                s2_tag <= s1_tag;
            end
            // Bubbles leave the previous result on out_d/out_tag.
            if (s2_valid) begin
                out_d   <= corr;
                out_tag <= s2_tag;
            end
        end
    end

`ifdef FP_ADDSUB_RANGE_CHK_EN
    logic s2_rerr;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_rerr   <= 1'b0;
            range_err <= 1'b0;
        end else if (adv) begin
            if (s1_valid) begin
                s2_rerr <= (s1_a >= Q) || (s1_b >= Q);
            end
            if (s2_valid) begin
                range_err <= s2_rerr;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Bench for fp_addsub_pipe: a W=8/Q=251 instance for directed tables, stall
// and reset sequences, and a default-parameter instance for boundary and
// randomized checks against an arithmetic reference model.

module tb_fp_addsub_pipe;

    localparam int S_W   = 8;
    localparam logic [S_W-1:0] S_Q = 8'd251;
    localparam int TAG_W = 4;
    localparam int BW    = 255;
    localparam logic [BW-1:0] BQ =
        255'd2261564242916331941866620800950935700259179388000792266395655937654553313279;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- small instance ----------------
    logic             s_in_valid = 1'b0;
    logic             s_in_ready;
    logic             s_in_op = 1'b0;
    logic [S_W-1:0]   s_in_a = '0;
    logic [S_W-1:0]   s_in_b = '0;
    logic [TAG_W-1:0] s_in_tag = '0;
    logic             s_out_valid;
    logic             s_out_ready = 1'b0;
    logic [S_W-1:0]   s_out_d;
    logic [TAG_W-1:0] s_out_tag;
`ifdef FP_ADDSUB_RANGE_CHK_EN
    logic             s_range_err;
    logic             b_range_err;
`endif

    fp_addsub_pipe #(.W(S_W), .Q(S_Q), .TAG_W(TAG_W)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_op(s_in_op),
        .in_a(s_in_a), .in_b(s_in_b), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_d(s_out_d), .out_tag(s_out_tag)
`ifdef FP_ADDSUB_RANGE_CHK_EN
        , .range_err(s_range_err)
`endif
    );

    // ---------------- default-parameter instance ----------------
    logic             b_in_valid = 1'b0;
    logic             b_in_ready;
    logic             b_in_op = 1'b0;
    logic [BW-1:0]    b_in_a = '0;
    logic [BW-1:0]    b_in_b = '0;
    logic [TAG_W-1:0] b_in_tag = '0;
    logic             b_out_valid;
    logic             b_out_ready = 1'b0;
    logic [BW-1:0]    b_out_d;
    logic [TAG_W-1:0] b_out_tag;

    fp_addsub_pipe dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
        .in_a(b_in_a), .in_b(b_in_b), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_d(b_out_d), .out_tag(b_out_tag)
`ifdef FP_ADDSUB_RANGE_CHK_EN
        , .range_err(b_range_err)
`endif
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [S_W+TAG_W:0]  exp_s_q[$];   // {err, tag, d}
    logic [BW+TAG_W-1:0] exp_b_q[$];   // {tag, d}

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain modular arithmetic for in-range operands.
    function automatic logic [BW-1:0] ref_big(input logic op, input logic [BW-1:0] a,
                                              input logic [BW-1:0] b);
        logic [BW:0] s;
        if (!op) begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, BQ}) s = s - {1'b0, BQ};
        end else if (a >= b) begin
            s = {1'b0, a} - {1'b0, b};
        end else begin
            s = {1'b0, a} + {1'b0, BQ} - {1'b0, b};
        end
        return s[BW-1:0];
    endfunction

    function automatic logic [BW-1:0] rand_fe();
        logic [255:0] r;
        logic [255:0] m;
        int sel;
        r = '0;
        for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom())};
        m = r % {1'b0, BQ};
        sel = $urandom_range(0, 9);
        if (sel == 0) return '0;
        if (sel == 1) return BQ - 1;
        return m[BW-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drive one cycle, score any output consumed at
    // the coming rising edge, record an accepted op, return at the next fall.
    task automatic step_s(input logic rdy, input logic pres, input logic op,
                          input logic [S_W-1:0] a, input logic [S_W-1:0] b,
                          input logic [TAG_W-1:0] tag, input logic [S_W-1:0] exp_d,
                          input logic exp_err, output logic acc);
        logic [S_W+TAG_W:0] e;
        s_out_ready = rdy;
        s_in_valid  = pres;
        s_in_op     = op;
        s_in_a      = a;
        s_in_b      = b;
        s_in_tag    = tag;
        #1;
        chk("s_in_ready_rule", s_in_ready, !s_out_valid || s_out_ready);
        acc = pres && s_in_ready;
        if (s_out_valid && s_out_ready) begin
            if (exp_s_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected: got d=%0d tag=%0d expected no result", s_out_d, s_out_tag);
            end else begin
                e = exp_s_q.pop_front();
                chk("s_out_d", s_out_d, e[S_W-1:0]);
                chk("s_out_tag", s_out_tag, e[S_W+TAG_W-1:S_W]);
`ifdef FP_ADDSUB_RANGE_CHK_EN
                chk("s_range_err", s_range_err, e[S_W+TAG_W]);
`endif
            end
        end
        if (acc) exp_s_q.push_back({exp_err, tag, exp_d});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_b(input logic rdy, input logic pres, input logic op,
                          input logic [BW-1:0] a, input logic [BW-1:0] b,
                          input logic [TAG_W-1:0] tag, input logic [BW-1:0] exp_d,
                          output logic acc);
        logic [BW+TAG_W-1:0] e;
        b_out_ready = rdy;
        b_in_valid  = pres;
        b_in_op     = op;
        b_in_a      = a;
        b_in_b      = b;
        b_in_tag    = tag;
        #1;
        chk("b_in_ready_rule", b_in_ready, !b_out_valid || b_out_ready);
        acc = pres && b_in_ready;
        if (b_out_valid && b_out_ready) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got d=%0h expected no result", b_out_d);
            end else begin
                e = exp_b_q.pop_front();
                chk("b_out_d", b_out_d, e[BW-1:0]);
                chk("b_out_tag", b_out_tag, e[BW+TAG_W-1:BW]);
            end
        end
        if (acc) exp_b_q.push_back({tag, exp_d});
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic             op;
        logic [S_W-1:0]   a;
        logic [S_W-1:0]   b;
        logic [TAG_W-1:0] tag;
        logic [S_W-1:0]   d;
        logic             err;
    } vec_t;

    vec_t tv[10];

    initial begin
        logic acc;
        int n;
        logic have_held, saw_drop;
        logic [S_W-1:0] held_d;
        logic rdy;
        logic p_op;
        logic [BW-1:0] p_a, p_b;
        logic [TAG_W-1:0] p_tag;
        logic have_pend;
        int nacc;

        tv[0] = '{1'b0, 8'd200, 8'd100, 4'd3,  8'd49,  1'b0};
        tv[1] = '{1'b1, 8'd5,   8'd10,  4'd1,  8'd246, 1'b0};
        tv[2] = '{1'b1, 8'd10,  8'd5,   4'd2,  8'd5,   1'b0};
        tv[3] = '{1'b0, 8'd250, 8'd0,   4'd4,  8'd250, 1'b0};
        tv[4] = '{1'b1, 8'd0,   8'd0,   4'd5,  8'd0,   1'b0};
        tv[5] = '{1'b0, 8'd250, 8'd250, 4'd6,  8'd249, 1'b0};
        tv[6] = '{1'b0, 8'd251, 8'd1,   4'd7,  8'd1,   1'b1};
        tv[7] = '{1'b0, 8'd250, 8'd1,   4'd8,  8'd0,   1'b0};
        tv[8] = '{1'b1, 8'd3,   8'd200, 4'd9,  8'd54,  1'b0};
        tv[9] = '{1'b0, 8'd1,   8'd2,   4'd10, 8'd3,   1'b0};

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_s_valid", s_out_valid, 0);
        chk("rst_s_d", s_out_d, 0);
        chk("rst_s_tag", s_out_tag, 0);
        chk("rst_s_in_ready", s_in_ready, 1);
        chk("rst_b_valid", b_out_valid, 0);
        chk("rst_b_d", b_out_d, 0);
        chk("rst_b_in_ready", b_in_ready, 1);
`ifdef FP_ADDSUB_RANGE_CHK_EN
        chk("rst_s_range_err", s_range_err, 0);
`endif
        @(negedge clk);

        // Latency of a single add: result visible after the third rising
        // edge counting the accept edge.
        step_s(1, 1, tv[0].op, tv[0].a, tv[0].b, tv[0].tag, tv[0].d, tv[0].err, acc);
        chk("lat_accept", acc, 1);
        chk("lat_valid_e1", s_out_valid, 0);
        step_s(1, 0, 0, 0, 0, 0, 0, 0, acc);
        chk("lat_valid_e2", s_out_valid, 0);
        step_s(1, 0, 0, 0, 0, 0, 0, 0, acc);
        chk("lat_valid_e3", s_out_valid, 1);
        chk("lat_d", s_out_d, 8'd49);
        chk("lat_tag", s_out_tag, 4'd3);
        step_s(1, 0, 0, 0, 0, 0, 0, 0, acc);

        // Back-to-back table entries, one per cycle
        for (int i = 1; i < 8; i++) begin
            step_s(1, 1, tv[i].op, tv[i].a, tv[i].b, tv[i].tag, tv[i].d, tv[i].err, acc);
            chk("b2b_accept", acc, 1);
        end
        for (int i = 0; i < 6; i++) step_s(1, 0, 0, 0, 0, 0, 0, 0, acc);
        chk("b2b_drained", exp_s_q.size(), 0);

        // Stall: out_ready low for 5 cycles while 4 ops are offered
        n = 0;
        have_held = 0;
        saw_drop = 0;
        held_d = '0;
        for (int c = 0; c < 30 && (n < 4 || exp_s_q.size() != 0); c++) begin
            rdy = (c >= 5);
            s_out_ready = rdy;
            #1;
            if (s_out_valid && !rdy) begin
                saw_drop = 1;
                chk("stall_in_ready", s_in_ready, 0);
                if (have_held) chk("stall_hold_d", s_out_d, held_d);
                else begin
                    held_d = s_out_d;
                    have_held = 1;
                end
            end
            if (n < 4) begin
                step_s(rdy, 1, tv[6+n].op, tv[6+n].a, tv[6+n].b, tv[6+n].tag,
                       tv[6+n].d, tv[6+n].err, acc);
                if (acc) n++;
            end else begin
                step_s(rdy, 0, 0, 0, 0, 0, 0, 0, acc);
            end
        end
        chk("stall_seen", saw_drop, 1);
        chk("stall_all_issued", n, 4);
        chk("stall_drained", exp_s_q.size(), 0);

        // Reset with three ops in flight (output held by a stall)
        step_s(0, 1, 0, 8'd7, 8'd8, 4'd1, 8'd15, 0, acc);
        step_s(0, 1, 0, 8'd1, 8'd1, 4'd2, 8'd2, 0, acc);
        step_s(0, 1, 1, 8'd3, 8'd1, 4'd3, 8'd2, 0, acc);
        chk("pre_rst_valid", s_out_valid, 1);
        s_in_valid = 0;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", s_out_valid, 0);
        chk("mid_rst_d", s_out_d, 0);
        chk("mid_rst_tag", s_out_tag, 0);
        rst = 0;
        exp_s_q.delete();
        for (int i = 0; i < 6; i++) step_s(1, 0, 0, 0, 0, 0, 0, 0, acc);

        // Default width: boundary cases
        step_b(1, 1, 1, '0, BQ - 1, 4'd1, 255'd1, acc);
        step_b(1, 1, 0, BQ - 1, BQ - 1, 4'd2, BQ - 2, acc);
        for (int i = 0; i < 5; i++) step_b(1, 0, 0, '0, '0, 0, '0, acc);
        chk("big_dir_drained", exp_b_q.size(), 0);

        // Default width: randomized ops with random output stalls
        nacc = 0;
        have_pend = 0;
        p_op = 0; p_a = '0; p_b = '0; p_tag = '0;
        for (int c = 0; c < 6000 && nacc < 1000; c++) begin
            if (!have_pend && $urandom_range(0, 4) != 0) begin
                p_op  = 1'($urandom_range(0, 1));
                p_a   = rand_fe();
                p_b   = rand_fe();
                p_tag = 4'($urandom_range(0, 15));
                have_pend = 1;
            end
            step_b($urandom_range(0, 3) != 0, have_pend, p_op, p_a, p_b, p_tag,
                   ref_big(p_op, p_a, p_b), acc);
            if (acc) begin
                have_pend = 0;
                nacc++;
            end
        end
        chk("rand_count", nacc, 1000);
        for (int i = 0; i < 10; i++) step_b(1, 0, 0, '0, '0, 0, '0, acc);
        chk("rand_drained", exp_b_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
